// File: rtl/booth_r4_seq_mult.sv
// Iterative signed radix-4 Booth multiplier.
// Retires one Booth digit per clock into a 2*WIDTH accumulator; valid/ready
// handshakes on operand and product sides.
// Optional build macro SIGNED_CTRL_EN adds an is_signed input. It selects
// signed or unsigned operands per transaction. In that build every
// transaction takes WIDTH/2+1 digits.
module booth_r4_seq_mult #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a_in,
    input  logic [WIDTH-1:0]     b_in,
`ifdef SIGNED_CTRL_EN
    input  logic                 is_signed,
`endif
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product
);

    localparam int unsigned PW   = 2 * WIDTH;
`ifdef SIGNED_CTRL_EN
    localparam int unsigned NDIG = WIDTH / 2 + 1;
    localparam int unsigned MW   = WIDTH + 3;
`else
    localparam int unsigned NDIG = WIDTH / 2;
    localparam int unsigned MW   = WIDTH + 1;
`endif
    localparam int unsigned CW   = $clog2(NDIG + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state;
    logic [PW-1:0]          mcand;
    logic signed [MW-1:0]   mreg;
    logic [PW-1:0]          acc;
    logic [CW-1:0]          cnt;

    logic [2:0]             digit;
    logic                   single, double, neg;
    logic [PW-1:0]          pp_mag;
    logic [PW-1:0]          pp;
    logic [PW-1:0]          acc_nxt;
    logic                   sext;
    logic                   last;

    // Sign-extension control for the operands sampled on the accept edge.
`ifdef SIGNED_CTRL_EN
    assign sext = is_signed;
`else
    assign sext = 1'b1;
`endif

    assign last = (cnt == CW'(NDIG - 1));

    // Booth digit decode and partial product for the current digit.
    always_comb begin
        digit   = mreg[2:0];
        single  = digit[0] ^ digit[1];
        double  = (digit == 3'b011) || (digit == 3'b100);
        neg     = digit[2];
        pp_mag  = '0;
        if (single) begin
            pp_mag = mcand;
        end else if (double) begin
            pp_mag = mcand << 1;
        end
        // For digit 111 the magnitude is zero, so the negation is also zero.
        pp      = neg ? (~pp_mag + PW'(1)) : pp_mag;
        acc_nxt = acc + (pp << {cnt, 1'b0});
    end

    // Control FSM with registered handshake outputs and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            product   <= '0;
            mcand     <= '0;
            mreg      <= '0;
            acc       <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mcand    <= {{WIDTH{a_in[WIDTH-1] & sext}}, a_in};
`ifdef SIGNED_CTRL_EN
                        mreg     <= {{2{b_in[WIDTH-1] & sext}}, b_in, 1'b0};
`else
                        mreg     <= {b_in, 1'b0};
`endif
                        acc      <= '0;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    acc  <= acc_nxt;
                    mreg <= mreg >>> 2;
                    cnt  <= cnt + CW'(1);
                    if (last) begin
                        product   <= acc_nxt;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/booth_r4_seq_mult.md
Name: booth_r4_seq_mult

Overview:
- Iterative signed radix-4 Booth multiplier that consumes the boothEnc digit outputs (single, double, neg).
- Retires one Booth digit per clock and accumulates the shifted partial products into a 2*WIDTH product.
- Sits between the operand source and the result sink, with valid/ready handshakes on both sides.
- Area-lean alternative to the parallel partial-product array.

Parameters:
- WIDTH, 8, operand width in bits; must be even and >= 4.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands present.
- in_ready  output  1  block can accept operands.
- a_in  input  WIDTH  multiplicand, two's complement.
- b_in  input  WIDTH  multiplier, two's complement.
- out_valid  output  1  product valid.
- out_ready  input  1  sink accepts product.
- product  output  2*WIDTH  a_in*b_in, two's complement.

Behaviour:
- Interface decision: one clock, clk; reset rst is synchronous and active-high.
- Reset values:
  - state=IDLE, product=0, out_valid=0.
  - in_ready=1 in the first cycle after rst deasserts.
- Reset mid-operation: aborts the computation, discards partial results, returns to IDLE.
- FSM states: IDLE, RUN, DONE.
  - in_ready = (state==IDLE); out_valid = (state==DONE).
- IDLE, on in_valid & in_ready:
  - mcand <= sign-extend(a_in) to 2*WIDTH.
  - mreg <= {b_in, 1'b0}.
  - acc <= 0; cnt <= 0; go to RUN.
- RUN, each cycle:
  - boothEnc digit input = mreg[2:0].
  - pp = single ? mcand : double ? mcand<<1 : 0.
  - If neg, pp = ~pp + 1, computed at full 2*WIDTH width. Digit 3'b111 (neg only) therefore yields pp=0.
  - acc <= acc + (pp << 2*cnt), truncated modulo 2^(2*WIDTH).
  - mreg <= mreg >>> 2 (arithmetic); cnt <= cnt+1.
  - After the last digit (cnt==NDIG-1): product <= final acc, go to DONE.
- Digit count: NDIG = WIDTH/2.
- Latency: out_valid asserts exactly NDIG cycles after the accept edge, i.e. 4 cycles for WIDTH=8.
- DONE:
  - product and out_valid held stable until out_ready=1, then go to IDLE.
  - Back-to-back: a new operand pair is accepted no earlier than the cycle after DONE exits. in_ready is never asserted while out_valid=1.
- Held-stable rule: in_valid while busy is ignored; a_in/b_in are sampled only on the accept edge.
- Extreme operands: -2^(W-1) * -2^(W-1) = +2^(2W-2) is representable and must be exact; no overflow flag.
- Counter: cnt width = clog2(NDIG+1).

Optional Feature:
- Macro: SIGNED_CTRL_EN
- Defined:
  - Adds input port is_signed (1 bit), sampled on the accept edge.
  - is_signed=1: behaviour as above.
  - is_signed=0: operands are treated as unsigned.
    - mcand is zero-extended.
    - mreg is loaded as {2'b00, b_in, 1'b0} (mreg widened by 2 bits).
    - NDIG = WIDTH/2+1; latency becomes WIDTH/2+1 cycles.
    - Product is the exact unsigned 2*WIDTH result.
- Undefined: no is_signed port; always signed; NDIG = WIDTH/2.

Test Plan:
- WIDTH=8, a=3, b=5, out_ready=1:
  - in_ready drops the cycle after accept.
  - out_valid rises 4 cycles after accept with product=16'h000F.
  - in_ready=1 the following cycle.
- a=-128, b=-128 -> product=16'h4000. a=-128, b=127 -> product=16'hC080 (-16256).
- a=0, b=-1; then a=-1, b=-1:
  - products 16'h0000 and 16'h0001.
  - Covers the digit 3'b111 -> zero partial product.
- Backpressure: out_ready=0 for 5 cycles after out_valid:
  - product/out_valid held stable.
  - in_valid pulses are ignored.
  - On out_ready=1, return to IDLE.
- Reset mid-RUN (rst on the 2nd cycle of RUN):
  - Next cycle: out_valid=0, product=0, in_ready=1.
  - A subsequent 7*-6 gives 16'hFFD6.
- SIGNED_CTRL_EN defined, is_signed=0, a=8'hFF, b=8'hFF:
  - product=16'hFE01 after 5 cycles.
  - Same operands with is_signed=1 -> 16'h0001 after 5 cycles.
